// File: rtl/lsq_writeback_if.sv
// Bundles the LSQ completion input, the data-memory port and the register-file/retire
// outputs of lsq_writeback. The design connects through slave; the environment connects through master.
interface lsq_writeback_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 8
);
    logic                                  cpl_valid;
    logic                                  cpl_is_store;
    logic [1:0]                            cpl_warp;
    logic [3:0]                            cpl_dest_reg;
    logic [LANES-1:0][ADDR_WIDTH-1:0]      cpl_addr;
    logic [LANES-1:0]                      cpl_mask;
    logic [LANES-1:0][DATA_WIDTH-1:0]      cpl_store_data;

    logic                                  mem_req;
    logic                                  mem_we;
    logic [ADDR_WIDTH-1:0]                 mem_addr;
    logic [DATA_WIDTH-1:0]                 mem_wdata;
    logic [DATA_WIDTH-1:0]                 mem_rdata;

    logic                                  rf_we;
    logic [1:0]                            rf_warp;
    logic [3:0]                            rf_reg;
    logic [LANES-1:0]                      rf_lane_mask;
    logic [LANES-1:0][DATA_WIDTH-1:0]      rf_wdata;

    logic                                  wb_done;
    logic [1:0]                            wb_warp;
    logic [3:0]                            wb_dest_reg;
    logic                                  wb_is_store;

    modport slave (
        input  cpl_valid, cpl_is_store, cpl_warp, cpl_dest_reg, cpl_addr, cpl_mask,
               cpl_store_data, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_warp, rf_reg, rf_lane_mask, rf_wdata,
               wb_done, wb_warp, wb_dest_reg, wb_is_store
    );

    modport master (
        output cpl_valid, cpl_is_store, cpl_warp, cpl_dest_reg, cpl_addr, cpl_mask,
               cpl_store_data, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_warp, rf_reg, rf_lane_mask, rf_wdata,
               wb_done, wb_warp, wb_dest_reg, wb_is_store
    );
endinterface

// File: rtl/lsq_writeback.sv
// LSQ writeback: buffers completed entries, walks their active lanes through the data memory
// and retires them to the register file. Define LSQ_WB_COALESCE_EN to reuse repeated load addresses.
module lsq_writeback #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int LANES      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    lsq_writeback_if.slave bus,
    output logic           overflow_err
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, WB} state_t;

    typedef struct packed {
        logic                             is_store;
        logic [1:0]                       warp;
        logic [3:0]                       dest;
        logic [LANES-1:0][ADDR_WIDTH-1:0] addr;
        logic [LANES-1:0]                 mask;
        logic [LANES-1:0][DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                           state_q, state_d;
    entry_t                           fifo_mem [FIFO_DEPTH];
    entry_t                           cpl_entry;
    entry_t                           work_q;
    entry_t                           head;
    logic [PW:0]                      wr_ptr, rd_ptr;
    logic                             fifo_empty, fifo_full, push, pop;
    logic [LANES-1:0]                 pend, pend_next;
    logic [LW-1:0]                    cur_lane;
    logic [LANES-1:0][DATA_WIDTH-1:0] lane_buf;
    logic                             cap_valid;
    logic [LW-1:0]                    cap_lane;
    logic [DATA_WIDTH-1:0]            cap_data;
    logic                             coal;

    assign cpl_entry  = '{is_store: bus.cpl_is_store, warp: bus.cpl_warp, dest: bus.cpl_dest_reg,
                          addr: bus.cpl_addr, mask: bus.cpl_mask, data: bus.cpl_store_data};
    assign head       = fifo_mem[rd_ptr[PW-1:0]];
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign push       = bus.cpl_valid && !fifo_full;

    // pend holds the lanes still to be visited; the lowest set bit is the lane served this cycle
    always_comb begin
        cur_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend[i]) cur_lane = LW'(i);
        end
        pend_next = pend & ~(LANES'(1) << cur_lane);
    end

`ifdef LSQ_WB_COALESCE_EN
    logic                  have_prev;
    logic [ADDR_WIDTH-1:0] prev_addr;
    logic                  cap_coal;
    logic [DATA_WIDTH-1:0] last_data;

    assign coal     = !work_q.is_store && have_prev && (work_q.addr[cur_lane] == prev_addr);
    assign cap_data = cap_coal ? last_data : bus.mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            have_prev <= 1'b0;
            prev_addr <= '0;
            cap_coal  <= 1'b0;
            last_data <= '0;
        end else begin
            if (pop) have_prev <= 1'b0;
            if (state_q == ACCESS) begin
                have_prev <= 1'b1;
                prev_addr <= work_q.addr[cur_lane];
            end
            cap_coal <= (state_q == ACCESS) && coal;
            if (cap_valid) last_data <= cap_data;
        end
    end
`else
    assign coal     = 1'b0;
    assign cap_data = bus.mem_rdata;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[PW-1:0]] <= cpl_entry;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            overflow_err <= 1'b0;
            work_q       <= '0;
            pend         <= '0;
            lane_buf     <= '0;
            cap_valid    <= 1'b0;
            cap_lane     <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            // full is judged before this cycle's pop, so a simultaneous pop does not save the push
            if (bus.cpl_valid && fifo_full) overflow_err <= 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                work_q   <= head;
                pend     <= head.mask;
                lane_buf <= '0;
            end
            if (state_q == ACCESS) pend <= pend_next;
            // read data returns one cycle after issue, so captures trail the lane walk by one cycle
            cap_valid <= (state_q == ACCESS) && !work_q.is_store;
            cap_lane  <= cur_lane;
            if (cap_valid) lane_buf[cap_lane] <= cap_data;
        end
    end

    always_comb begin
        state_d          = state_q;
        pop              = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.rf_we        = 1'b0;
        bus.rf_warp      = '0;
        bus.rf_reg       = '0;
        bus.rf_lane_mask = '0;
        bus.rf_wdata     = '0;
        bus.wb_done      = 1'b0;
        bus.wb_warp      = '0;
        bus.wb_dest_reg  = '0;
        bus.wb_is_store  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = (head.mask != '0) ? ACCESS : WB;
                end
            end
            ACCESS: begin
                bus.mem_req   = !coal;
                bus.mem_we    = work_q.is_store;
                bus.mem_addr  = work_q.addr[cur_lane];
                bus.mem_wdata = work_q.is_store ? work_q.data[cur_lane] : '0;
                if (pend_next == '0) state_d = work_q.is_store ? WB : DRAIN;
            end
            DRAIN: begin
                state_d = WB;
            end
            WB: begin
                bus.wb_done     = 1'b1;
                bus.wb_warp     = work_q.warp;
                bus.wb_dest_reg = work_q.dest;
                bus.wb_is_store = work_q.is_store;
                if (!work_q.is_store && work_q.mask != '0) begin
                    bus.rf_we        = 1'b1;
                    bus.rf_warp      = work_q.warp;
                    bus.rf_reg       = work_q.dest;
                    bus.rf_lane_mask = work_q.mask;
                    bus.rf_wdata     = lane_buf;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lsq_writeback.sv
// Bench for lsq_writeback: directed scenarios plus random entries, each predicted by a
// lane-by-lane memory model and checked with immediate assertions.
module tb_lsq_writeback;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int L  = 8;
    localparam int FD = 4;

    typedef struct {
        bit                   is_store;
        logic [1:0]           warp;
        logic [3:0]           dest;
        logic [L-1:0][AW-1:0] addr;
        logic [L-1:0]         mask;
        logic [L-1:0][DW-1:0] sdata;
    } entry_t;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    typedef struct {
        int                   cyc;
        logic                 wb_done;
        logic                 wb_is_store;
        logic                 rf_we;
        logic [1:0]           wb_warp;
        logic [1:0]           rf_warp;
        logic [3:0]           wb_dest;
        logic [3:0]           rf_reg;
        logic [L-1:0]         rf_mask;
        logic [L-1:0][DW-1:0] rf_wdata;
    } wb_t;

    logic clk = 1'b0;
    logic reset;
    logic overflow_err;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    acc_t          mem_log [$];
    wb_t           wb_log  [$];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;

    lsq_writeback_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(L)) bus ();

    lsq_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LANES(L), .FIFO_DEPTH(FD)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory: reads answer one cycle later, otherwise the read bus carries noise
    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int a = 0; a < 256; a++) mem[a] <= DW'(a + 100);
        end
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_req === 1'b1 && bus.mem_we === 1'b0) bus.mem_rdata <= mem[bus.mem_addr];
        else bus.mem_rdata <= DW'($urandom);
    end

    always @(negedge clk) begin
        acc_t a;
        wb_t  w;
        if (bus.mem_req === 1'b1) begin
            a.we    = bus.mem_we;
            a.addr  = bus.mem_addr;
            a.wdata = bus.mem_wdata;
            mem_log.push_back(a);
        end
        if (bus.wb_done !== 1'b0 || bus.rf_we !== 1'b0) begin
            w.cyc         = cyc;
            w.wb_done     = bus.wb_done;
            w.wb_is_store = bus.wb_is_store;
            w.rf_we       = bus.rf_we;
            w.wb_warp     = bus.wb_warp;
            w.rf_warp     = bus.rf_warp;
            w.wb_dest     = bus.wb_dest_reg;
            w.rf_reg      = bus.rf_reg;
            w.rf_mask     = bus.rf_lane_mask;
            w.rf_wdata    = bus.rf_wdata;
            wb_log.push_back(w);
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input entry_t e, output int c);
        bus.cpl_is_store   = e.is_store;
        bus.cpl_warp       = e.warp;
        bus.cpl_dest_reg   = e.dest;
        bus.cpl_addr       = e.addr;
        bus.cpl_mask       = e.mask;
        bus.cpl_store_data = e.sdata;
        bus.cpl_valid      = 1'b1;
        c = cyc;
        @(posedge clk);
        #1;
        bus.cpl_valid = 1'b0;
    endtask

    task automatic waitRetire(input int n, input int budget);
        int k = 0;
        while (wb_log.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("retire_count", wb_log.size(), n);
    endtask

    // Predict one entry from the lane rules: accesses in ascending active-lane order,
    // loads see the memory as left by earlier entries, stores update it lane by lane.
    task automatic checkEntry(input entry_t e, input int t_pop, output int wb_exp);
        acc_t                 exp_acc [$];
        acc_t                 x, a;
        wb_t                  w;
        logic [L-1:0][DW-1:0] exp_data = '0;
        int                   n = 0;
        bit                   pv = 0;
        bit                   coal;
        logic [AW-1:0]        pa = '0;
        for (int i = 0; i < L; i++) begin
            if (e.mask[i]) begin
                n++;
                coal = 0;
`ifdef LSQ_WB_COALESCE_EN
                coal = !e.is_store && pv && (e.addr[i] == pa);
`endif
                if (!coal) begin
                    x.we    = e.is_store;
                    x.addr  = e.addr[i];
                    x.wdata = e.is_store ? e.sdata[i] : DW'(0);
                    exp_acc.push_back(x);
                end
                if (e.is_store) ref_mem[e.addr[i]] = e.sdata[i];
                else exp_data[i] = ref_mem[e.addr[i]];
                pv = 1;
                pa = e.addr[i];
            end
        end
        wb_exp = t_pop + ((n == 0) ? 1 : (e.is_store ? n + 1 : n + 2));
        foreach (exp_acc[j]) begin
            if (mem_log.size() == 0) begin
                checkOutput("mem_missing", 0, 1);
            end else begin
                a = mem_log.pop_front();
                checkOutput("mem_we", a.we, exp_acc[j].we);
                checkOutput("mem_addr", a.addr, exp_acc[j].addr);
                checkOutput("mem_wdata", a.wdata, exp_acc[j].wdata);
            end
        end
        if (wb_log.size() == 0) begin
            checkOutput("wb_missing", 0, 1);
        end else begin
            w = wb_log.pop_front();
            checkOutput("wb_cycle", w.cyc, wb_exp);
            checkOutput("wb_done", w.wb_done, 1);
            checkOutput("wb_warp", w.wb_warp, e.warp);
            checkOutput("wb_dest_reg", w.wb_dest, e.dest);
            checkOutput("wb_is_store", w.wb_is_store, e.is_store);
            checkOutput("rf_we", w.rf_we, (!e.is_store && n > 0));
            if (!e.is_store && n > 0) begin
                checkOutput("rf_warp", w.rf_warp, e.warp);
                checkOutput("rf_reg", w.rf_reg, e.dest);
                checkOutput("rf_lane_mask", w.rf_mask, e.mask);
                checkOutput("rf_wdata", w.rf_wdata, exp_data);
            end
        end
    endtask

    function automatic entry_t randEntry();
        entry_t e;
        e.is_store = 1'($urandom_range(0, 1));
        e.warp     = 2'($urandom);
        e.dest     = 4'($urandom);
        case ($urandom_range(0, 5))
            0:       e.mask = '0;
            1:       e.mask = '1;
            default: e.mask = L'($urandom);
        endcase
        for (int i = 0; i < L; i++) begin
            e.addr[i]  = AW'(8'h80 + $urandom_range(0, 5));
            e.sdata[i] = DW'($urandom);
        end
        return e;
    endfunction

    task automatic runSingle(input entry_t e);
        int c, wbe;
        applyStimulus(e, c);
        waitRetire(1, 60);
        checkEntry(e, c + 1, wbe);
        checkOutput("mem_extra", mem_log.size(), 0);
        checkOutput("wb_extra", wb_log.size(), 0);
    endtask

    initial begin
        int     c, c0, t, wbe, k;
        entry_t e;
        entry_t burst [6];

        reset              = 1'b0;
        bus.cpl_valid      = 1'b0;
        bus.cpl_is_store   = 1'b0;
        bus.cpl_warp       = '0;
        bus.cpl_dest_reg   = '0;
        bus.cpl_addr       = '0;
        bus.cpl_mask       = '0;
        bus.cpl_store_data = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = DW'(a + 100);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_mem_req", bus.mem_req, 0);
        checkOutput("reset_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
        checkOutput("reset_rf_we", bus.rf_we, 0);
        checkOutput("reset_rf_bus", {bus.rf_warp, bus.rf_reg, bus.rf_lane_mask}, 0);
        checkOutput("reset_rf_wdata", bus.rf_wdata, 0);
        checkOutput("reset_wb", {bus.wb_done, bus.wb_warp, bus.wb_dest_reg, bus.wb_is_store}, 0);
        checkOutput("reset_overflow", overflow_err, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed load, store and empty-mask entries");
        e.is_store = 0; e.warp = 2; e.dest = 5; e.mask = 8'hFF;
        for (int i = 0; i < L; i++) begin
            e.addr[i]  = AW'(i + 16);
            e.sdata[i] = DW'($urandom);
        end
        runSingle(e);
        e.is_store = 1; e.warp = 1; e.dest = 9; e.mask = 8'b1010_0001;
        for (int i = 0; i < L; i++) begin
            e.addr[i]  = AW'(i + 32);
            e.sdata[i] = DW'(16'hA0 + i);
        end
        runSingle(e);
        e.is_store = 0; e.warp = 3; e.dest = 12; e.mask = 8'h00;
        runSingle(e);

        $display("[TB] repeated-address load");
        e.is_store = 1; e.warp = 0; e.dest = 0; e.mask = 8'h01;
        e.addr[0] = 8'h40; e.sdata[0] = 16'h1234;
        runSingle(e);
        e.is_store = 0; e.warp = 1; e.dest = 7; e.mask = 8'hFF;
        for (int i = 0; i < L; i++) e.addr[i] = 8'h40;
        runSingle(e);

        $display("[TB] reset during a load walk");
        e.is_store = 0; e.warp = 2; e.dest = 3; e.mask = 8'hFF;
        for (int i = 0; i < L; i++) e.addr[i] = AW'($urandom);
        applyStimulus(e, c);
        k = 0;
        while (bus.mem_req !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        checkOutput("reset_wait_req", bus.mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_mem_req", bus.mem_req, 0);
        checkOutput("async_mem_addr", bus.mem_addr, 0);
        checkOutput("async_rf_wb", {bus.rf_we, bus.wb_done}, 0);
        mem_log.delete();
        wb_log.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("post_reset_wb", wb_log.size(), 0);
        checkOutput("post_reset_mem", mem_log.size(), 0);

        $display("[TB] burst of six completions into a four-entry buffer");
        burst[0].is_store = 0; burst[0].warp = 1; burst[0].dest = 2; burst[0].mask = 8'hFF;
        for (int i = 0; i < L; i++) begin
            burst[0].addr[i]  = AW'($urandom);
            burst[0].sdata[i] = '0;
        end
        for (int j = 1; j < 6; j++) burst[j] = randEntry();
        applyStimulus(burst[0], c0);
        for (int j = 1; j < 6; j++) applyStimulus(burst[j], c);
        checkOutput("overflow_set", overflow_err, 1);
        waitRetire(5, 150);
        t = c0 + 1;
        for (int j = 0; j < 5; j++) begin
            checkEntry(burst[j], t, wbe);
            t = wbe + 1;
        end
        checkOutput("burst_mem_extra", mem_log.size(), 0);
        checkOutput("burst_wb_extra", wb_log.size(), 0);
        checkOutput("overflow_sticky", overflow_err, 1);
        reset = 1'b0;
        #1;
        checkOutput("overflow_cleared", overflow_err, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] random single entries");
        for (int r = 0; r < 12; r++) runSingle(randEntry());

        $display("[TB] random back-to-back entries");
        for (int j = 0; j < 4; j++) burst[j] = randEntry();
        applyStimulus(burst[0], c0);
        for (int j = 1; j < 4; j++) applyStimulus(burst[j], c);
        waitRetire(4, 150);
        t = c0 + 1;
        for (int j = 0; j < 4; j++) begin
            checkEntry(burst[j], t, wbe);
            t = wbe + 1;
        end
        checkOutput("rand_burst_mem_extra", mem_log.size(), 0);
        checkOutput("rand_burst_overflow", overflow_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
